wb_register_file: RTL and testbench

General-register file at the consumer end of the MEM/WB pipeline register: it takes the write-back destination, data and load-enable from the WB stage and commits them into 32 × 32-bit architectural registers. It serves three combinational read ports for the ID stage: A, B, and the store-data operand. Write-through bypass lets an ID-stage read in the same cycle as a WB write see the new value. GR0 reads as zero and is never written.

---
 rtl/wb_register_file_pkg.sv | 13 +
 rtl/wb_register_file_reg_read_port.sv | 28 ++
 rtl/wb_register_file.sv | 89 ++++++++
 tb/tb_wb_register_file.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/wb_register_file_pkg.sv
// Pipeline-wide constants and types shared by the register file and its read ports.
package wb_register_file_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned NUM_GR = 32;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [ADDR_W-1:0] addr_t;

  localparam addr_t GR_ZERO = 5'd0;

endpackage

// File: rtl/wb_register_file_reg_read_port.sv
// One combinational register-file read port with write-back bypass.
module reg_read_port
  import wb_register_file_pkg::*;
(
  input  logic  Reset,
  input  addr_t addr,
  input  data_t gr [NUM_GR],
  input  data_t wb_pd,
  input  addr_t wb_rd,
  input  logic  wb_le,
  output data_t data
);

  always_comb begin
    data = '0;
    if (Reset) begin
      data = '0;
    end else if (addr == GR_ZERO) begin
      data = '0;
    end else if (wb_le && (wb_rd == addr)) begin
      // Same-cycle write-through so ID sees the value WB is committing now.
      data = wb_pd;
    end else begin
      data = gr[addr];
    end
  end

endmodule

// File: rtl/wb_register_file.sv
// 32 x 32-bit general register file: one WB write port, three bypassed ID read ports.
module wb_register_file
  import wb_register_file_pkg::*;
(
  input  logic              clk,
  input  logic              Reset,
  input  logic [DATA_W-1:0] WB_PD_in,
  input  logic [ADDR_W-1:0] WB_RD_in,
  input  logic              WB_RF_LE_in,
  input  logic [ADDR_W-1:0] RA_in,
  input  logic [ADDR_W-1:0] RB_in,
  input  logic [ADDR_W-1:0] RC_in,
  output logic [DATA_W-1:0] PA_out,
  output logic [DATA_W-1:0] PB_out,
  output logic [DATA_W-1:0] PC_out,
  output logic [31:0]       WB_COUNT_out
);

  // GR0 has no storage; the read view ties entry 0 to zero.
  data_t       gr_q [1:NUM_GR-1];
  data_t       gr_view [NUM_GR];
  logic        wr_en;
  logic [31:0] wb_count_q, wb_count_d;

  assign wr_en = WB_RF_LE_in && (WB_RD_in != GR_ZERO);

  always_comb begin
    gr_view[0] = '0;
    for (int i = 1; i < NUM_GR; i++) begin
      gr_view[i] = gr_q[i];
    end
  end

  always_comb begin
    wb_count_d = wb_count_q;
    if (wr_en) begin
      wb_count_d = wb_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      for (int i = 1; i < NUM_GR; i++) begin
        gr_q[i] <= '0;
      end
      wb_count_q <= '0;
    end else begin
      for (int i = 1; i < NUM_GR; i++) begin
        if (wr_en && (WB_RD_in == addr_t'(i))) begin
          gr_q[i] <= WB_PD_in;
        end
      end
      wb_count_q <= wb_count_d;
    end
  end

  assign WB_COUNT_out = wb_count_q;

  reg_read_port u_port_a (
    .Reset (Reset),
    .addr  (RA_in),
    .gr    (gr_view),
    .wb_pd (WB_PD_in),
    .wb_rd (WB_RD_in),
    .wb_le (WB_RF_LE_in),
    .data  (PA_out)
  );

  reg_read_port u_port_b (
    .Reset (Reset),
    .addr  (RB_in),
    .gr    (gr_view),
    .wb_pd (WB_PD_in),
    .wb_rd (WB_RD_in),
    .wb_le (WB_RF_LE_in),
    .data  (PB_out)
  );

  reg_read_port u_port_c (
    .Reset (Reset),
    .addr  (RC_in),
    .gr    (gr_view),
    .wb_pd (WB_PD_in),
    .wb_rd (WB_RD_in),
    .wb_le (WB_RF_LE_in),
    .data  (PC_out)
  );

endmodule

// File: tb/tb_wb_register_file.sv
// Directed self-checking bench for wb_register_file.
module tb_wb_register_file;

  logic        clk;
  logic        Reset;
  logic [31:0] WB_PD_in;
  logic [4:0]  WB_RD_in;
  logic        WB_RF_LE_in;
  logic [4:0]  RA_in, RB_in, RC_in;
  logic [31:0] PA_out, PB_out, PC_out;
  logic [31:0] WB_COUNT_out;

  int checks = 0;
  int errors = 0;

  wb_register_file dut (
    .clk          (clk),
    .Reset        (Reset),
    .WB_PD_in     (WB_PD_in),
    .WB_RD_in     (WB_RD_in),
    .WB_RF_LE_in  (WB_RF_LE_in),
    .RA_in        (RA_in),
    .RB_in        (RB_in),
    .RC_in        (RC_in),
    .PA_out       (PA_out),
    .PB_out       (PB_out),
    .PC_out       (PC_out),
    .WB_COUNT_out (WB_COUNT_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] rd, input logic [31:0] pd, input logic le);
    WB_RD_in    = rd;
    WB_PD_in    = pd;
    WB_RF_LE_in = le;
  endtask

  task automatic test_reset();
    Reset = 1'b1; wr(5'd0, 32'h0, 1'b0);
    tick();
    Reset = 1'b0;
    wr(5'd5, 32'hDEAD_BEEF, 1'b1);
    tick();
    wr(5'd0, 32'h0, 1'b0); RA_in = 5'd5; #1;
    checks++;
    if (PA_out !== 32'hDEAD_BEEF) begin
      $display("FAIL preload_gr5 got %h want %h", PA_out, 32'hDEAD_BEEF); errors++;
    end
    Reset = 1'b1; wr(5'd7, 32'h11, 1'b1); RB_in = 5'd7; #1;
    checks++;
    if (PA_out !== 32'h0 || PB_out !== 32'h0) begin
      $display("FAIL read_during_reset got %h/%h want 0", PA_out, PB_out); errors++;
    end
    tick();
    Reset = 1'b0; wr(5'd0, 32'h0, 1'b0); #1;
    checks++;
    if (PA_out !== 32'h0) begin
      $display("FAIL gr5_after_reset got %h want 0", PA_out); errors++;
    end
    checks++;
    if (PB_out !== 32'h0) begin
      $display("FAIL gr7_write_dropped got %h want 0", PB_out); errors++;
    end
    checks++;
    if (WB_COUNT_out !== 32'd0) begin
      $display("FAIL count_after_reset got %0d want 0", WB_COUNT_out); errors++;
    end
  endtask

  task automatic test_basic();
    wr(5'd3, 32'h1234_5678, 1'b1);
    tick();
    wr(5'd0, 32'h0, 1'b0); RA_in = 5'd3; RC_in = 5'd3; #1;
    checks++;
    if (PA_out !== 32'h1234_5678) begin
      $display("FAIL basic_pa got %h want %h", PA_out, 32'h1234_5678); errors++;
    end
    checks++;
    if (PC_out !== 32'h1234_5678) begin
      $display("FAIL basic_pc got %h want %h", PC_out, 32'h1234_5678); errors++;
    end
    checks++;
    if (WB_COUNT_out !== 32'd1) begin
      $display("FAIL basic_count got %0d want 1", WB_COUNT_out); errors++;
    end
  endtask

  task automatic test_gr0();
    wr(5'd0, 32'hFFFF_FFFF, 1'b1); RA_in = 5'd0; #1;
    checks++;
    if (PA_out !== 32'h0) begin
      $display("FAIL gr0_same_cycle got %h want 0", PA_out); errors++;
    end
    tick();
    wr(5'd0, 32'h0, 1'b0); #1;
    checks++;
    if (PA_out !== 32'h0) begin
      $display("FAIL gr0_next_cycle got %h want 0", PA_out); errors++;
    end
    checks++;
    if (WB_COUNT_out !== 32'd1) begin
      $display("FAIL gr0_count got %0d want 1", WB_COUNT_out); errors++;
    end
  endtask

  task automatic test_bypass();
    wr(5'd9, 32'hAAAA_0000, 1'b1);
    tick();
    wr(5'd0, 32'h0, 1'b0); RB_in = 5'd9; #1;
    checks++;
    if (PB_out !== 32'hAAAA_0000) begin
      $display("FAIL bypass_preload got %h want %h", PB_out, 32'hAAAA_0000); errors++;
    end
    wr(5'd9, 32'h0000_5555, 1'b1); RA_in = 5'd3; #1;
    checks++;
    if (PB_out !== 32'h0000_5555) begin
      $display("FAIL bypass_same_cycle got %h want %h", PB_out, 32'h5555); errors++;
    end
    checks++;
    if (PA_out !== 32'h1234_5678) begin
      $display("FAIL bypass_other_port got %h want %h", PA_out, 32'h1234_5678); errors++;
    end
    tick();
    wr(5'd0, 32'h0, 1'b0); #1;
    checks++;
    if (PB_out !== 32'h0000_5555) begin
      $display("FAIL bypass_stored got %h want %h", PB_out, 32'h5555); errors++;
    end
    checks++;
    if (WB_COUNT_out !== 32'd3) begin
      $display("FAIL bypass_count got %0d want 3", WB_COUNT_out); errors++;
    end
  endtask

  task automatic test_le_low();
    wr(5'd4, 32'h0000_4444, 1'b1);
    tick();
    wr(5'd4, 32'h0000_CAFE, 1'b0); RA_in = 5'd4; #1;
    checks++;
    if (PA_out !== 32'h0000_4444) begin
      $display("FAIL le_low_same_cycle got %h want %h", PA_out, 32'h4444); errors++;
    end
    tick();
    #1;
    checks++;
    if (PA_out !== 32'h0000_4444) begin
      $display("FAIL le_low_no_store got %h want %h", PA_out, 32'h4444); errors++;
    end
    checks++;
    if (WB_COUNT_out !== 32'd4) begin
      $display("FAIL le_low_count got %0d want 4", WB_COUNT_out); errors++;
    end
  endtask

  task automatic test_back_to_back();
    wr(5'd2, 32'd1, 1'b1);
    tick();
    wr(5'd2, 32'd2, 1'b1); RA_in = 5'd2; RB_in = 5'd2; RC_in = 5'd2; #1;
    checks++;
    if (PA_out !== 32'd2 || PB_out !== 32'd2 || PC_out !== 32'd2) begin
      $display("FAIL b2b_bypass_all_ports got %h/%h/%h want 2", PA_out, PB_out, PC_out);
      errors++;
    end
    tick();
    wr(5'd0, 32'h0, 1'b0); #1;
    checks++;
    if (PA_out !== 32'd2 || PB_out !== 32'd2 || PC_out !== 32'd2) begin
      $display("FAIL b2b_last_wins got %h/%h/%h want 2", PA_out, PB_out, PC_out); errors++;
    end
    checks++;
    if (WB_COUNT_out !== 32'd6) begin
      $display("FAIL b2b_count got %0d want 6", WB_COUNT_out); errors++;
    end
  endtask

  task automatic test_wrap();
    wr(5'd0, 32'h0, 1'b0);
    force dut.wb_count_q = 32'hFFFF_FFFF;
    #1;
    release dut.wb_count_q;
    #1;
    checks++;
    if (WB_COUNT_out !== 32'hFFFF_FFFF) begin
      $display("FAIL wrap_preset got %h want ffffffff", WB_COUNT_out); errors++;
    end
    wr(5'd6, 32'h0000_0066, 1'b1);
    tick();
    wr(5'd0, 32'h0, 1'b0); RA_in = 5'd6; #1;
    checks++;
    if (WB_COUNT_out !== 32'h0) begin
      $display("FAIL wrap_to_zero got %h want 0", WB_COUNT_out); errors++;
    end
    checks++;
    if (PA_out !== 32'h0000_0066) begin
      $display("FAIL wrap_write_data got %h want %h", PA_out, 32'h66); errors++;
    end
  endtask

  initial begin
    Reset = 1'b1;
    WB_PD_in = '0; WB_RD_in = '0; WB_RF_LE_in = 1'b0;
    RA_in = '0; RB_in = '0; RC_in = '0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_gr0();
    test_bypass();
    test_le_low();
    test_back_to_back();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
